small_image_uart_sender: RTL and testbench

Consumer stage for the small-image pixel index generator. The generator walks the 320×240 frame buffer at 2× decimation. This block latches each 12-bit pixel that the frame-buffer RAM returns for the current `address`, and transmits it as two 8N1 UART bytes. It paces the generator through `pixel_send_ready`: ready is high only while waiting for the next address, so a new address is issued only after the previous pixel has fully left the wire. One frame (160×120 = 19200 pixels, 38400 bytes) is sent per `start`.

---
 rtl/small_image_uart_sender_if.sv | 22 ++
 rtl/small_image_uart_sender.sv | 159 +++++++++++++++
 tb/tb_small_image_uart_sender.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/small_image_uart_sender_if.sv
// Handshake and data bundle between the pixel index generator, frame-buffer RAM
// and the small-image UART sender.
interface small_image_uart_sender_if;
    logic        start;
    logic [16:0] address;
    logic [11:0] pixel_data;
    logic        pixel_send_ready;
    logic        uart_tx;
    logic        busy;
    logic        frame_done;
    logic [14:0] pixels_sent;

    modport master (
        output start, address, pixel_data,
        input  pixel_send_ready, uart_tx, busy, frame_done, pixels_sent
    );

    modport slave (
        input  start, address, pixel_data,
        output pixel_send_ready, uart_tx, busy, frame_done, pixels_sent
    );
endinterface

// File: rtl/small_image_uart_sender.sv
// Latches each 12-bit frame-buffer pixel and ships it as two 8N1 UART bytes,
// pacing the index generator so a new address is taken only after the line is free.
module small_image_uart_sender #(
    parameter int NUM_PIXELS   = 76800,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                     clk,
    input  logic                     rst,
    small_image_uart_sender_if.slave bus
);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [17:0]       END_ADDR  = 18'(NUM_PIXELS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ADDR = 3'd1,
        FETCH     = 3'd2,
        LATCH     = 3'd3,
        TX        = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [16:0]      last_addr_r, last_addr_nxt_s;
    logic [11:0]      pix_r, pix_nxt_s;
    logic             byte_sel_r, byte_sel_nxt_s;
    logic [3:0]       bit_idx_r, bit_idx_nxt_s;
    logic [CNT_W-1:0] baud_r, baud_nxt_s;
    logic             tx_r, tx_nxt_s;
    logic [14:0]      sent_r, sent_nxt_s;
    logic             ready_r, busy_r, frame_done_r;

    // Line level for bit slot idx of a frame: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic uart_bit(input logic [11:0] pix, input logic byte_sel,
                                      input logic [3:0] idx);
        logic [7:0] data_v;
        logic [2:0] sel_v;
        data_v = byte_sel ? pix[7:0] : {4'b0000, pix[11:8]};
        sel_v  = idx[2:0] - 3'd1;
        case (idx)
            4'd0:    uart_bit = 1'b0;
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8:
                     uart_bit = data_v[sel_v];
            default: uart_bit = 1'b1;
        endcase
    endfunction

    // Next-state and next-register computation for the sender FSM.
    always_comb begin
        state_nxt_s     = state_r;
        last_addr_nxt_s = last_addr_r;
        pix_nxt_s       = pix_r;
        byte_sel_nxt_s  = byte_sel_r;
        bit_idx_nxt_s   = bit_idx_r;
        baud_nxt_s      = baud_r;
        tx_nxt_s        = 1'b1;
        sent_nxt_s      = sent_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    last_addr_nxt_s = bus.address;
                    sent_nxt_s      = 15'd0;
                    state_nxt_s     = FETCH;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end
            WAIT_ADDR: begin
                if (bus.address != last_addr_r) begin
                    last_addr_nxt_s = bus.address;
                    state_nxt_s     = FETCH;
                end else begin
                    state_nxt_s     = WAIT_ADDR;
                end
            end
            FETCH: begin
                if ({1'b0, last_addr_r} >= END_ADDR) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = LATCH;
                end
            end
            LATCH: begin
                pix_nxt_s      = bus.pixel_data;
                byte_sel_nxt_s = 1'b0;
                bit_idx_nxt_s  = 4'd0;
                baud_nxt_s     = '0;
                tx_nxt_s       = 1'b0;
                state_nxt_s    = TX;
            end
            TX: begin
                tx_nxt_s = tx_r;
                if (baud_r == BAUD_LAST) begin
                    baud_nxt_s = '0;
                    if (bit_idx_r == 4'd9) begin
                        if (byte_sel_r) begin
                            // Second stop bit done: the pixel has fully left the wire.
                            tx_nxt_s    = 1'b1;
                            sent_nxt_s  = (sent_r == 15'h7FFF) ? sent_r : sent_r + 15'd1;
                            state_nxt_s = WAIT_ADDR;
                        end else begin
                            byte_sel_nxt_s = 1'b1;
                            bit_idx_nxt_s  = 4'd0;
                            tx_nxt_s       = 1'b0;
                        end
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 4'd1;
                        tx_nxt_s      = uart_bit(pix_r, byte_sel_r, bit_idx_r + 4'd1);
                    end
                end else begin
                    baud_nxt_s = baud_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so they stay registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_addr_r  <= 17'd0;
            pix_r        <= 12'd0;
            byte_sel_r   <= 1'b0;
            bit_idx_r    <= 4'd0;
            baud_r       <= '0;
            tx_r         <= 1'b1;
            sent_r       <= 15'd0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_addr_r  <= last_addr_nxt_s;
            pix_r        <= pix_nxt_s;
            byte_sel_r   <= byte_sel_nxt_s;
            bit_idx_r    <= bit_idx_nxt_s;
            baud_r       <= baud_nxt_s;
            tx_r         <= tx_nxt_s;
            sent_r       <= sent_nxt_s;
            ready_r      <= (state_nxt_s == WAIT_ADDR);
            busy_r       <= (state_nxt_s != IDLE);
            frame_done_r <= (state_nxt_s == DONE);
        end
    end

    assign bus.uart_tx          = tx_r;
    assign bus.pixel_send_ready = ready_r;
    assign bus.busy             = busy_r;
    assign bus.frame_done       = frame_done_r;
    assign bus.pixels_sent      = sent_r;
endmodule

// File: tb/tb_small_image_uart_sender.sv
// Self-checking bench: table of single pixels, reset/start corner cases, and a
// generator + RAM model run over a shortened frame, with a UART byte scoreboard.
module tb_small_image_uart_sender;
    localparam int CPB = 4;
    localparam int NP  = 1280;
    localparam int TD  = 2;

    logic clk;
    logic rst;
    logic [11:0] pix_drive;
    logic        ram_mode;

    small_image_uart_sender_if bus();

    small_image_uart_sender #(.NUM_PIXELS(NP), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM: either returns address[11:0] or a bench-chosen value.
    always @(posedge clk) bus.pixel_data <= ram_mode ? bus.address[11:0] : pix_drive;

    int n_vec  = 0;
    int n_miss = 0;
    int fd_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_pix(input logic [11:0] p);
        exp_q.push_back({4'b0000, p[11:8]});
        exp_q.push_back(p[7:0]);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (bus.pixel_send_ready !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk(nm, 32'(bus.pixel_send_ready), 32'h1);
    endtask

    // Frame-done pulse counter.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
    end

    // UART receiver: samples mid-bit, checks framing, ready-low and byte value.
    logic       mon_act, mon_rdy, mon_start_ok;
    int         mon_cnt, mon_k;
    logic [7:0] mon_byte;
    initial begin
        mon_act = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_act = 1'b0;
            end else if (!mon_act) begin
                if (bus.uart_tx === 1'b0) begin
                    mon_act = 1'b1; mon_cnt = 0; mon_start_ok = 1'b1;
                    mon_rdy = bus.pixel_send_ready;
                end
            end else begin
                mon_cnt++;
                if (bus.pixel_send_ready === 1'b1) mon_rdy = 1'b1;
                if (mon_cnt % CPB == CPB / 2) begin
                    mon_k = mon_cnt / CPB;
                    if (mon_k == 0) mon_start_ok = (bus.uart_tx === 1'b0);
                    else if (mon_k <= 8) mon_byte[mon_k-1] = bus.uart_tx;
                    else begin
                        mon_act = 1'b0;
                        chk("rx_framing", 32'({mon_start_ok, bus.uart_tx}), 32'h3);
                        chk("ready_low_in_tx", 32'(mon_rdy), 32'h0);
                        if (exp_q.size() == 0) begin
                            n_vec++; n_miss++;
                            $display("FAIL rx_unexpected: got byte 0x%0h, expected none", mon_byte);
                        end else begin
                            chk("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [16:0] addr;
        logic [11:0] pix;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [14:0] sent;
    } vec_t;
    vec_t vt[4];

    initial begin
        int k, fd0, gx, gy, dcnt, a;
        vt[0] = '{addr: 17'd0,   pix: 12'hA5C, b0: 8'h0A, b1: 8'h5C, sent: 15'd1};
        vt[1] = '{addr: 17'd2,   pix: 12'hFFF, b0: 8'h0F, b1: 8'hFF, sent: 15'd2};
        vt[2] = '{addr: 17'd4,   pix: 12'h000, b0: 8'h00, b1: 8'h00, sent: 15'd3};
        vt[3] = '{addr: 17'd640, pix: 12'h123, b0: 8'h01, b1: 8'h23, sent: 15'd4};

        rst = 1'b0; bus.start = 1'b0; bus.address = 17'd0; pix_drive = 12'd0; ram_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_uart_tx", 32'(bus.uart_tx), 32'h1);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ready", 32'(bus.pixel_send_ready), 32'h0);
        chk("rst_pixels_sent", 32'(bus.pixels_sent), 32'h0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'h0);

        // Table of pixels: first via start, the rest via address changes.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vt[i].b0);
            exp_q.push_back(vt[i].b1);
            if (i == 0) begin
                bus.address = vt[i].addr; pix_drive = vt[i].pix;
                pulse_start();
                chk("start_busy", 32'(bus.busy), 32'h1);
                chk("fetch_line_idle", 32'(bus.uart_tx), 32'h1);
                @(negedge clk);
                chk("latch_line_idle", 32'(bus.uart_tx), 32'h1);
                @(negedge clk);
                chk("tx_start_bit", 32'(bus.uart_tx), 32'h0);
                k = 0;
                while (bus.pixel_send_ready !== 1'b1 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                chk("tx_duration", 32'(k), 32'(20 * CPB));
            end else begin
                @(negedge clk);
                bus.address = vt[i].addr; pix_drive = vt[i].pix;
                @(posedge clk);
                @(negedge clk);
                wait_ready("vec_ready_timeout");
            end
            chk("vec_pixels_sent", 32'(bus.pixels_sent), 32'(vt[i].sent));
        end

        // End of frame via out-of-range address: no bytes, one pulse.
        fd0 = fd_cnt;
        @(negedge clk) bus.address = 17'(NP);
        repeat (8) @(negedge clk);
        chk("eof_frame_done", 32'(fd_cnt - fd0), 32'h1);
        chk("eof_busy", 32'(bus.busy), 32'h0);
        chk("eof_pixels_sent", 32'(bus.pixels_sent), 32'h4);
        chk("eof_queue_empty", 32'(exp_q.size()), 32'h0);

        // Reset during data bit 3 of byte 1.
        bus.address = 17'd5; pix_drive = 12'h3C7;
        push_pix(12'h3C7);
        pulse_start();
        repeat (2 + 14 * CPB) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_uart_tx", 32'(bus.uart_tx), 32'h1);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_pixels_sent", 32'(bus.pixels_sent), 32'h0);
        chk("midrst_byte0_only", 32'(exp_q.size()), 32'h1);
        exp_q.delete();
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Clean resend from the current address, with an ignored start mid-TX.
        push_pix(12'h3C7);
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        @(negedge clk);
        wait_ready("resend_ready_timeout");
        chk("resend_pixels_sent", 32'(bus.pixels_sent), 32'h1);
        chk("resend_queue_empty", 32'(exp_q.size()), 32'h0);
        fd0 = fd_cnt;
        @(negedge clk) bus.address = 17'(NP);
        repeat (8) @(negedge clk);
        chk("resend_eof", 32'(fd_cnt - fd0), 32'h1);

        // Generator + RAM model over a 4-row frame.
        ram_mode = 1'b1; gx = 0; gy = 0; dcnt = 0;
        bus.address = 17'd0;
        push_pix(12'h000);
        fd0 = fd_cnt;
        pulse_start();
        k = 0;
        while (fd_cnt == fd0 && k < 40000) begin
            @(negedge clk);
            k++;
            if (bus.pixel_send_ready === 1'b1) begin
                dcnt++;
                if (dcnt == TD + 1) begin
                    dcnt = 0;
                    gx += 2;
                    if (gx >= 320) begin gx = 0; gy += 2; end
                    a = gy * 320 + gx;
                    bus.address = 17'(a);
                    if (a < NP) push_pix(12'(a));
                end
            end else begin
                dcnt = 0;
            end
        end
        if (k >= 40000) chk("gen_frame_timeout", 32'(fd_cnt - fd0), 32'h1);
        repeat (3) @(negedge clk);
        chk("gen_pixels_sent", 32'(bus.pixels_sent), 32'(NP / 4));
        chk("gen_frame_done_once", 32'(fd_cnt - fd0), 32'h1);
        chk("gen_busy_idle", 32'(bus.busy), 32'h0);
        chk("gen_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("gen_line_idle", 32'(bus.uart_tx), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
